// File: rtl/uart_rx_if.sv
// Byte delivery port of the UART receiver: valid/ready handshake carrying one received word.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling strobe; delivers bytes on a valid/ready port.
// Optional parity check is enabled by defining UART_PARITY_EN.
module uart_rx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_tick,
    input  logic       rx,
    uart_rx_if.master  rx_port,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // Elaboration guard on the supported parameter ranges.
    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0) ||
        (SYNC_STAGES < 2) || (PARITY_ODD > 1)) begin : g_bad_param
        $error("uart_rx: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
`ifdef UART_PARITY_EN
        ,
        ST_PARITY
`endif
    } state_e;

    state_e               state_q,  state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]        tick_q,   tick_d;
    logic [BW-1:0]        bit_q,    bit_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 valid_q,  valid_d;
    logic                 fe_q,     fe_d;
    logic                 ov_q,     ov_d;
    logic                 byte_done;
    logic                 rx_s;
`ifdef UART_PARITY_EN
    logic                 par_q,    par_d;
    logic                 pe_q,     pe_d;
    logic                 par_bad;

    // Data bits xor parity bit must equal the configured sense.
    assign par_bad = ((^shift_q) ^ par_q) != 1'(PARITY_ODD);
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        byte_done = 1'b0;
`ifdef UART_PARITY_EN
        par_d     = par_q;
        pe_d      = 1'b0;
`endif

        if (valid_q && rx_port.rx_ready) begin
            valid_d = 1'b0;
        end

        if (rx_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        // LSB arrives first, so shifting right lands it in bit 0 after the last bit.
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BW'(1);
                        tick_d  = '0;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        par_d   = rx_s;
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rx_s) begin
                            state_d = ST_IDLE;
`ifdef UART_PARITY_EN
                            if (par_bad) begin
                                pe_d = 1'b1;
                            end else begin
                                byte_done = 1'b1;
                            end
`else
                            byte_done = 1'b1;
`endif
                        end else begin
                            fe_d    = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_BREAK: begin
                    // Hold here so a line stuck low reports one framing error only.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end
            endcase
        end

        if (byte_done) begin
            if (!valid_q || rx_port.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
            pe_q    <= pe_d;
`endif
        end
    end

    assign rx_port.rx_data  = data_q;
    assign rx_port.rx_valid = valid_q;
    assign frame_err        = fe_q;
    assign overrun_err      = ov_q;
`ifdef UART_PARITY_EN
    assign parity_err       = pe_q;
`else
    assign parity_err       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames checked against a frame-level model.
module tb_uart_rx;

    localparam int unsigned DB = 8;
    localparam int unsigned OS = 16;
    localparam int unsigned PAR_ODD = 0;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_tick = 1'b0;
    logic rx = 1'b1;
    logic frame_err, overrun_err, parity_err;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .SYNC_STAGES(2),
        .PARITY_ODD (PAR_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rx         (rx),
        .rx_port    (bus),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Oversampling strobe: one pulse every tick_div clocks (1 = held high).
    int tick_div = 3;
    int div_cnt = 0;
    int tick_no = 0;
    always @(negedge clk) begin
        if (div_cnt >= tick_div - 1) begin
            div_cnt = 0;
            rx_tick = 1'b1;
        end else begin
            div_cnt++;
            rx_tick = 1'b0;
        end
    end
    always @(posedge clk) if (rx_tick) tick_no <= tick_no + 1;

    // Frame-level reference: bytes expected to be delivered, plus expected error pulse counts.
    logic [7:0] exp_q[$];
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int n_fe = 0, n_ov = 0, n_pe = 0, n_rise = 0;
    int rise_tick = -1;
    logic [7:0] rise_data = '0;
    int hi_len = 0, last_len = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (frame_err)   n_fe++;
        if (overrun_err) n_ov++;
        if (parity_err)  n_pe++;
        if (bus.rx_valid && !prev_valid) begin
            n_rise++;
            rise_tick = tick_no;
            rise_data = bus.rx_data;
        end
        if (bus.rx_valid) hi_len++;
        else if (prev_valid) begin
            last_len = hi_len;
            hi_len = 0;
        end
        if (bus.rx_valid && bus.rx_ready && !rst) begin
            check("xfer_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check("xfer_data", 32'(bus.rx_data), 32'(exp_b));
            end
        end
        prev_valid = bus.rx_valid;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!rx_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_fe"}, 32'(n_fe), 32'(exp_fe));
        check({tag, "_ov"}, 32'(n_ov), 32'(exp_ov));
        check({tag, "_pe"}, 32'(n_pe), 32'(exp_pe));
    endtask

    // Drive one frame and record what the model says it must produce.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit par_ok,
                              input int low_hold, output int start_tick);
        if (!stop_ok)                            exp_fe++;
        else if (PAR_EN && !par_ok)              exp_pe++;
        else if (!bus.rx_ready && exp_q.size() > 0) exp_ov++;
        else                                     exp_q.push_back(data);
        wait_ticks(1);
        start_tick = tick_no;
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < DB; i++) begin
            rx = data[i];
            wait_ticks(OS);
        end
        if (PAR_EN) begin
            rx = (^data) ^ 1'(PAR_ODD) ^ !par_ok;
            wait_ticks(OS);
        end
        rx = stop_ok;
        wait_ticks(OS);
        if (!stop_ok && low_hold > 0) wait_ticks(low_hold);
        rx = 1'b1;
        wait_ticks(4);
    endtask

    int st;
    int rises;
    logic [7:0] pat;
    logic [7:0] rdata;
    bit r_stop, r_par;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_data",  32'(bus.rx_data),  32'd0);
        check("rst_fe",    32'(frame_err),    32'd0);
        check("rst_ov",    32'(overrun_err),  32'd0);
        check("rst_pe",    32'(parity_err),   32'd0);
        rst = 1'b0;
        wait_ticks(20);

        // 1: nominal frame; detect tick follows the 2-flop sync, then mid-start + 9 bit periods.
        send_frame(8'h55, 1'b1, 1'b1, 0, st);
        check("t1_latency", 32'(rise_tick - st), 32'(1 + OS / 2 + OS * (DB + 1)));
        check("t1_data",    32'(rise_data), 32'h55);
        check("t1_width",   32'(last_len), 32'd1);
        check("t1_valid",   32'(bus.rx_valid), 32'd0);
        check_errs("t1");

        // 2: short low glitch is rejected.
        rises = n_rise;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(24);
        check("t2_rises", 32'(n_rise), 32'(rises));
        check("t2_valid", 32'(bus.rx_valid), 32'd0);
        check_errs("t2");

        // 3: bad stop bit with line then held low: one framing error, then clean frame.
        rises = n_rise;
        send_frame(8'hA3, 1'b0, 1'b1, 40, st);
        check("t3_rises", 32'(n_rise), 32'(rises));
        check("t3_valid", 32'(bus.rx_valid), 32'd0);
        check_errs("t3");
        send_frame(8'h3C, 1'b1, 1'b1, 0, st);
        check("t3_data", 32'(rise_data), 32'h3C);
        check_errs("t3b");

        // 4: consumer stalled, second byte overruns.
        bus.rx_ready = 1'b0;
        wait_ticks(2);
        send_frame(8'h11, 1'b1, 1'b1, 0, st);
        send_frame(8'h22, 1'b1, 1'b1, 0, st);
        check("t4_valid", 32'(bus.rx_valid), 32'd1);
        check("t4_data",  32'(bus.rx_data),  32'h11);
        check_errs("t4");
        bus.rx_ready = 1'b1;
        wait_ticks(2);
        check("t4_cleared", 32'(bus.rx_valid), 32'd0);
        check("t4_qempty",  32'(exp_q.size()), 32'd0);

        // 5: reset in the middle of a frame.
        pat = 8'hF0;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            rx = pat[i];
            wait_ticks(OS);
        end
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t5_valid", 32'(bus.rx_valid), 32'd0);
        check("t5_data",  32'(bus.rx_data),  32'd0);
        rst = 1'b0;
        wait_ticks(20);
        check_errs("t5");
        send_frame(8'h0F, 1'b1, 1'b1, 0, st);
        check("t5_data2", 32'(rise_data), 32'h0F);
        check_errs("t5b");

`ifdef UART_PARITY_EN
        // 6: parity good then bad.
        send_frame(8'h07, 1'b1, 1'b1, 0, st);
        check("t6_data", 32'(rise_data), 32'h07);
        rises = n_rise;
        send_frame(8'h07, 1'b1, 1'b0, 0, st);
        check("t6_rises", 32'(n_rise), 32'(rises));
        send_frame(8'h5A, 1'b0, 1'b0, 0, st);
        check_errs("t6");
`endif

        // Randomized frames: rate, ready, stop and parity faults all varied.
        for (int k = 0; k < 24; k++) begin
            tick_div = $urandom_range(1, 4);
            bus.rx_ready = ($urandom_range(0, 3) != 0);
            wait_ticks(2);
            rdata  = 8'($urandom);
            r_stop = ($urandom_range(0, 5) != 0);
            r_par  = ($urandom_range(0, 4) != 0);
            send_frame(rdata, r_stop, r_par, $urandom_range(0, 20), st);
        end
        bus.rx_ready = 1'b1;
        wait_ticks(4);
        check("rnd_qempty", 32'(exp_q.size()), 32'd0);
        check("rnd_valid",  32'(bus.rx_valid), 32'd0);
        check_errs("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
